// File: rtl/master_if_rd_pkg.sv
// Shared definitions for the master read engine: FSM encoding, default widths, latency bound.
package master_if_rd_pkg;

    localparam int DEF_AW     = 12;
    localparam int DEF_DW     = 32;
    localparam int DEF_SW     = 4;
    localparam int DEF_LW     = 8;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_BURST = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/rd_lat_pipe.sv
// Tracks accepted beats through the slave read latency: {valid,last} shift register
// plus an "anything still in flight" flag used to leave DRAIN.
module rd_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last,
    output logic outstanding
);

    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] last_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= in_valid;
            last_pipe[0] <= in_valid & in_last;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    // Tap is valid in the cycle the slave presents the data word.
    assign out_valid   = vld_pipe[RD_LAT-1];
    assign out_last    = last_pipe[RD_LAT-1];
    assign outstanding = |vld_pipe;

endmodule

// File: rtl/master_if_rd.sv
// Master-side burst read engine for one xbar read port: command in, address beats out,
// read data returned as a push stream. MASTER_IF_RD_TIMEOUT_EN adds a stall timeout and oTimeout-style pulse.
module master_if_rd
    import master_if_rd_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int SW     = DEF_SW,
    parameter int LW     = DEF_LW,
    parameter int RD_LAT = 1
`ifdef MASTER_IF_RD_TIMEOUT_EN
    ,
    parameter int TO_CYC = 255
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_addr,
    input  logic [SW-1:0] cmd_sel,
    input  logic [LW-1:0] cmd_len,
    output logic          mst_rd_req,
    output logic          mst_rd_valid,
    output logic [AW-1:0] mst_rd_addr,
    output logic [SW-1:0] mst_rd_sel,
    output logic          mst_rd_last,
    input  logic          mst_rd_ready,
    input  logic [DW-1:0] mst_rd_data,
    output logic          data_valid,
    output logic [DW-1:0] data,
    output logic          data_last,
    output logic          busy
`ifdef MASTER_IF_RD_TIMEOUT_EN
    ,
    output logic          timeout
`endif
);

    state_e        state, state_nxt;
    logic [AW-1:0] addr_q;
    logic [SW-1:0] sel_q;
    logic [LW-1:0] cnt_q;
    logic          arb_q;
    logic          accept;
    logic          pipe_valid, pipe_last, outstanding;
    logic          to_hit;

    assign accept = mst_rd_valid & mst_rd_ready;

`ifdef MASTER_IF_RD_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    logic [TW-1:0] to_q;
    logic          stalled;

    assign stalled = ((state == ST_ARB) || (state == ST_BURST)) && !accept;
    assign to_hit  = stalled && (to_q == TW'(TO_CYC - 1));
    assign timeout = to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_q <= '0;
        else if (stalled && !to_hit)
            to_q <= to_q + 1'b1;
        else
            to_q <= '0;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (cmd_valid)                  state_nxt = ST_ARB;
            ST_ARB:   if (arb_q)                      state_nxt = ST_BURST;
            ST_BURST: if (accept && (cnt_q == '0))    state_nxt = ST_DRAIN;
            ST_DRAIN: if (!outstanding)               state_nxt = ST_IDLE;
            default:                                  state_nxt = ST_IDLE;
        endcase
        if (to_hit) state_nxt = ST_DRAIN;
    end

    // cmd_ready is qualified by rst_n so every output reads 0 while reset is held.
    always_comb begin
        cmd_ready    = 1'b0;
        mst_rd_req   = 1'b0;
        mst_rd_valid = 1'b0;
        mst_rd_last  = 1'b0;
        unique case (state)
            ST_IDLE:  cmd_ready = rst_n;
            ST_ARB:   mst_rd_req = 1'b1;
            ST_BURST: begin
                mst_rd_req   = 1'b1;
                mst_rd_valid = 1'b1;
                mst_rd_last  = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    assign busy        = (state != ST_IDLE);
    assign mst_rd_addr = addr_q;
    assign mst_rd_sel  = sel_q;

    // arb_q marks the second ARB cycle; cnt_q stops at zero so a full-length burst cannot underflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            sel_q  <= '0;
            cnt_q  <= '0;
            arb_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (cmd_valid) begin
                    addr_q <= cmd_addr;
                    sel_q  <= cmd_sel;
                    cnt_q  <= cmd_len;
                    arb_q  <= 1'b0;
                end
                ST_ARB: arb_q <= 1'b1;
                ST_BURST: if (accept) begin
                    addr_q <= addr_q + 1'b1;
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    rd_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (accept),
        .in_last     (mst_rd_last),
        .out_valid   (pipe_valid),
        .out_last    (pipe_last),
        .outstanding (outstanding)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_valid <= 1'b0;
            data_last  <= 1'b0;
            data       <= '0;
        end else begin
            data_valid <= pipe_valid;
            data_last  <= pipe_valid & pipe_last;
            if (pipe_valid) data <= mst_rd_data;
        end
    end

endmodule

// File: tb/tb_master_if_rd.sv
// Directed bench for master_if_rd: cycle-indexed expectation model plus literal spot checks.
module tb_master_if_rd;

    localparam int AW = 12, DW = 32, SW = 4, LW = 8, RD_LAT = 2;
    localparam logic [31:0] TAG = 32'hC0DE_0000;

    logic          clk, rst_n;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [SW-1:0] cmd_sel;
    logic [LW-1:0] cmd_len;
    logic          mst_rd_req, mst_rd_valid, mst_rd_last, mst_rd_ready;
    logic [AW-1:0] mst_rd_addr;
    logic [SW-1:0] mst_rd_sel;
    logic [DW-1:0] mst_rd_data, data;
    logic          data_valid, data_last, busy;
`ifdef MASTER_IF_RD_TIMEOUT_EN
    logic          timeout;
`endif

    master_if_rd #(
        .AW(AW), .DW(DW), .SW(SW), .LW(LW), .RD_LAT(RD_LAT)
`ifdef MASTER_IF_RD_TIMEOUT_EN
        , .TO_CYC(8)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .mst_rd_req(mst_rd_req), .mst_rd_valid(mst_rd_valid),
        .mst_rd_addr(mst_rd_addr), .mst_rd_sel(mst_rd_sel), .mst_rd_last(mst_rd_last),
        .mst_rd_ready(mst_rd_ready), .mst_rd_data(mst_rd_data),
        .data_valid(data_valid), .data(data), .data_last(data_last),
        .busy(busy)
`ifdef MASTER_IF_RD_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    bit model_en = 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model: data bus carries a tag of the current cycle, so a latency error changes the value.
    initial begin
        mst_rd_data = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1 mst_rd_data = TAG ^ 32'(cyc);
        end
    end

    // Model state: one active burst, described by accept cycle and remaining beat addresses.
    bit            m_active;
    int            m_cmd, m_last;
    logic [SW-1:0] m_sel;
    logic [AW-1:0] m_addr_q[$];
    bit            exp_v[int];
    bit            exp_l[int];
    logic [DW-1:0] exp_d[int];
    logic [AW-1:0] acc_q[$];
    int            dv_cnt, dl_cnt;

    task automatic model_clear();
        m_active = 0;
        m_last   = -1;
        m_addr_q.delete();
        exp_v.delete();
        exp_l.delete();
        exp_d.delete();
    endtask

    initial begin
        model_clear();
        forever begin
            @(negedge clk);
            if (!rst_n || !model_en) begin
                model_clear();
                continue;
            end
            begin
                int  t;
                bit  e_busy, e_req, e_valid, e_dv;
                t = cyc;
                if (m_active && m_last >= 0 && t > m_last + RD_LAT + 1) m_active = 0;
                e_busy  = m_active;
                e_req   = m_active && m_last < 0;
                e_valid = e_req && t >= m_cmd + 3;
                chk("busy", busy, e_busy);
                chk("cmd_ready", cmd_ready, !e_busy);
                chk("req", mst_rd_req, e_req);
                chk("valid", mst_rd_valid, e_valid);
                if (e_valid) begin
                    chk("addr", mst_rd_addr, m_addr_q[0]);
                    chk("last", mst_rd_last, m_addr_q.size() == 1);
                    chk("sel", mst_rd_sel, m_sel);
                end
                e_dv = exp_v.exists(t);
                chk("data_valid", data_valid, e_dv);
                if (e_dv) begin
                    chk("data", data, exp_d[t]);
                    chk("data_last", data_last, exp_l[t]);
                    exp_v.delete(t);
                    exp_d.delete(t);
                    exp_l.delete(t);
                end
                if (data_valid) begin
                    dv_cnt++;
                    if (data_last) dl_cnt++;
                end
                if (e_valid && mst_rd_ready) begin
                    exp_v[t + RD_LAT + 1] = 1;
                    exp_d[t + RD_LAT + 1] = TAG ^ 32'(t + RD_LAT);
                    exp_l[t + RD_LAT + 1] = (m_addr_q.size() == 1);
                    acc_q.push_back(m_addr_q[0]);
                    if (m_addr_q.size() == 1) m_last = t;
                    void'(m_addr_q.pop_front());
                end
                if (!e_busy && cmd_valid) begin
                    m_active = 1;
                    m_cmd    = t;
                    m_last   = -1;
                    m_sel    = cmd_sel;
                    for (int i = 0; i <= int'(cmd_len); i++)
                        m_addr_q.push_back(cmd_addr + AW'(i));
                end
            end
        end
    end

    task automatic send_cmd(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [LW-1:0] l);
        bit ok = 0;
        cmd_addr  = a;
        cmd_sel   = s;
        cmd_len   = l;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk("cmd_accept_wait", ok, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!busy) begin ok = 1; break; end
        end
        chk(nm, ok, 1);
    endtask

    task automatic wait_valid(input string nm);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (mst_rd_valid) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        chk(nm, ok, 1);
    endtask

    task automatic start_test();
        acc_q.delete();
        dv_cnt = 0;
        dl_cnt = 0;
    endtask

    task automatic chk_addrs(input string nm, input logic [AW-1:0] e[], input int ndv);
        chk({nm, "_nbeats"}, acc_q.size(), e.size());
        for (int i = 0; i < e.size() && i < acc_q.size(); i++)
            chk({nm, "_beat_addr"}, acc_q[i], e[i]);
        chk({nm, "_ndata"}, dv_cnt, ndv);
        chk({nm, "_nlast"}, dl_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench hung");
    end

    initial begin
        logic [AW-1:0] e4[];
        logic [AW-1:0] e1[];
        logic [AW-1:0] e2[];
        bit pat[7];
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_sel = '0; cmd_len = '0;
        mst_rd_ready = 1'b1;
        #2;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_req", mst_rd_req, 0);
        chk("rst_valid", mst_rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_valid", data_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Basic 4-beat burst, Ready held high.
        start_test();
        send_cmd(12'h010, 4'd2, 8'd3);
        chk("t1_arb1_req", mst_rd_req, 1);
        chk("t1_arb1_valid", mst_rd_valid, 0);
        @(posedge clk); #1;
        chk("t1_arb2_req", mst_rd_req, 1);
        chk("t1_arb2_valid", mst_rd_valid, 0);
        @(posedge clk); #1;
        chk("t1_first_valid", mst_rd_valid, 1);
        chk("t1_first_addr", mst_rd_addr, 12'h010);
        chk("t1_first_sel", mst_rd_sel, 4'd2);
        wait_idle("t1_idle");
        e4 = new[4];
        e4[0] = 12'h010; e4[1] = 12'h011; e4[2] = 12'h012; e4[3] = 12'h013;
        chk_addrs("t1", e4, 4);

        // Single beat at the top of the address space.
        start_test();
        send_cmd(12'hFFF, 4'd5, 8'd0);
        wait_idle("t2_idle");
        e1 = new[1];
        e1[0] = 12'hFFF;
        chk_addrs("t2", e1, 1);
        chk("t2_cmd_ready", cmd_ready, 1);

        // Address wrap.
        start_test();
        send_cmd(12'hFFE, 4'd1, 8'd3);
        wait_idle("t3_idle");
        e4[0] = 12'hFFE; e4[1] = 12'hFFF; e4[2] = 12'h000; e4[3] = 12'h001;
        chk_addrs("t3", e4, 4);

        // Ready toggling 1,0,0,1,1,0,1 from the first valid cycle.
        start_test();
        mst_rd_ready = 1'b0;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        send_cmd(12'h020, 4'd7, 8'd3);
        wait_valid("t4_wait_valid");
        mst_rd_ready = pat[0];
        for (int i = 1; i < 7; i++) begin
            @(posedge clk); #1;
            mst_rd_ready = pat[i];
        end
        @(posedge clk); #1;
        mst_rd_ready = 1'b1;
        wait_idle("t4_idle");
        e4[0] = 12'h020; e4[1] = 12'h021; e4[2] = 12'h022; e4[3] = 12'h023;
        chk_addrs("t4", e4, 4);

        // Reset in the middle of a burst, then a fresh command.
        start_test();
        send_cmd(12'h100, 4'd1, 8'd7);
        wait_valid("t5_wait_valid");
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req", mst_rd_req, 0);
        chk("t5_rst_valid", mst_rd_valid, 0);
        chk("t5_rst_addr", mst_rd_addr, 0);
        chk("t5_rst_last", mst_rd_last, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cmd_ready", cmd_ready, 0);
        chk("t5_rst_data_valid", data_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_test();
        send_cmd(12'h200, 4'd3, 8'd1);
        wait_idle("t5_idle");
        e2 = new[2];
        e2[0] = 12'h200; e2[1] = 12'h201;
        chk_addrs("t5", e2, 2);

`ifdef MASTER_IF_RD_TIMEOUT_EN
        // Stalled burst: timeout pulses once and the engine returns to IDLE.
        begin
            int to_cnt = 0;
            model_en = 0;
            mst_rd_ready = 1'b0;
            send_cmd(12'h300, 4'd0, 8'd3);
            for (int i = 0; i < 30; i++) begin
                if (timeout) to_cnt++;
                @(posedge clk); #1;
            end
            chk("t6_timeout_pulses", to_cnt, 1);
            chk("t6_req", mst_rd_req, 0);
            chk("t6_busy", busy, 0);
            chk("t6_cmd_ready", cmd_ready, 1);
            mst_rd_ready = 1'b1;
            model_en = 1;
        end
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
